// File: rtl/dpram_stream_reader.sv
// Streams a contiguous address range out of one port of a 1-cycle-latency block RAM.
// A 4-entry buffer absorbs in-flight reads so downstream backpressure never drops data.
module dpram_stream_reader #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] start_addr,
  input  logic [ADDRWIDTH:0]   length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  input  logic [DATAWIDTH-1:0] mem_q,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  // state | meaning
  // IDLE  | waiting for start; length 0 just pulses done
  // RUN   | issuing reads, buffer may also be draining
  // DRAIN | all reads issued, emptying buffer
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDRWIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDRWIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDRWIDTH:0]   CNT_ZERO = '0;

  logic [1:0]           state;
  logic [ADDRWIDTH-1:0] addr_ptr;
  logic [ADDRWIDTH:0]   issue_left;
  logic [ADDRWIDTH:0]   pop_left;
  logic [2:0]           occ;
  logic                 rd_pend;
  logic [DATAWIDTH-1:0] buf_mem [0:3];
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [2:0]           buf_cnt;
  logic                 done_q;
  logic                 pop;

  assign mem_en    = (state == S_RUN) && (issue_left != CNT_ZERO) && (occ < 3'd4);
  assign mem_addr  = addr_ptr;
  assign out_valid = (buf_cnt != 3'd0);
  assign out_data  = buf_mem[rd_ptr];
  assign out_last  = out_valid && (pop_left == CNT_ONE);
  assign pop       = out_valid && out_ready;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_ptr   <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      occ        <= '0;
      rd_pend    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      buf_cnt    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < 4; i++) buf_mem[i] <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_pend <= mem_en;
      if (rd_pend) begin
        buf_mem[wr_ptr] <= mem_q;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        pop_left <= pop_left - CNT_ONE;
      end
      buf_cnt <= buf_cnt + {2'b00, rd_pend} - {2'b00, pop};
      occ     <= occ + {2'b00, mem_en} - {2'b00, pop};
      if (mem_en) begin
        addr_ptr   <= addr_ptr + ADDR_ONE;
        issue_left <= issue_left - CNT_ONE;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (length != CNT_ZERO) begin
              state      <= S_RUN;
              addr_ptr   <= start_addr;
              issue_left <= length;
              pop_left   <= length;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (mem_en && issue_left == CNT_ONE) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && pop_left == CNT_ONE) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Abort overrides everything above, including the read whose data lands this edge.
      if (abort && state != S_IDLE) begin
        state      <= S_IDLE;
        issue_left <= '0;
        pop_left   <= '0;
        occ        <= '0;
        rd_pend    <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        buf_cnt    <= '0;
        done_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader with a behavioural 1-cycle-latency RAM
// preloaded with mem[i] = i.
module tb_dpram_stream_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic       abort;
  logic       busy;
  logic       done;
  logic       mem_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_q;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  logic [7:0] ram [0:255];

  int vectors = 0;
  int miscompares = 0;

  dpram_stream_reader #(.DATAWIDTH(8), .ADDRWIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_q(mem_q),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_en) mem_q <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic ready_fn(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (cyc >= 5 && cyc <= 14) return 1'b0;
    if (cyc >= 25 && cyc <= 34) return 1'b0;
    return (cyc % 3) != 1;
  endfunction

  // Runs one transfer to completion, checking issue order, occupancy, stall
  // stability, data order, out_last and done timing.
  task automatic run_stream(input logic [7:0] sa, input int len, input int mode);
    int issued = 0;
    int got = 0;
    int occ_m = 0;
    int done_cyc = -1;
    logic stall_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_addr;
    start = 1'b1; start_addr = sa; length = 9'(len);
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < len * 4 + 60; cyc++) begin
      out_ready = ready_fn(mode, cyc);
      #1;
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (mem_en) begin
        exp_addr = sa + 8'(issued);
        check("issue_addr", 32'(mem_addr), 32'(exp_addr));
        check("issue_occ_lt4", 32'(occ_m < 4), 32'd1);
        issued++;
        occ_m++;
      end
      if (out_valid && out_ready) begin
        exp_addr = sa + 8'(got);
        check("out_data", 32'(out_data), 32'(exp_addr));
        check("out_last", 32'(out_last), 32'(got == len - 1));
        got++;
        occ_m--;
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_at_done", 32'(busy), 32'd0);
        break;
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      tick();
    end
    check("done_seen", 32'(done_cyc > 0), 32'd1);
    check("words_out", 32'(got), 32'(len));
    check("words_issued", 32'(issued), 32'(len));
    if (mode == 0) check("done_cycle", 32'(done_cyc), 32'(len + 3));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    abort = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    // Scenario 1: exact cycle timing
    start = 1'b1; start_addr = 8'h10; length = 9'd4;
    tick();
    start = 1'b0;
    check("s1_c1_busy", 32'(busy), 32'd1);
    check("s1_c1_mem_en", 32'(mem_en), 32'd1);
    check("s1_c1_addr", 32'(mem_addr), 32'h10);
    tick();
    check("s1_c2_valid", 32'(out_valid), 32'd0);
    check("s1_c2_addr", 32'(mem_addr), 32'h11);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("s1_valid", 32'(out_valid), 32'd1);
      check("s1_data", 32'(out_data), 32'(8'h10 + 8'(k)));
      check("s1_last", 32'(out_last), 32'(k == 3));
      check("s1_no_done", 32'(done), 32'd0);
    end
    tick();
    check("s1_c7_done", 32'(done), 32'd1);
    check("s1_c7_busy", 32'(busy), 32'd0);
    check("s1_c7_valid", 32'(out_valid), 32'd0);
    tick();
    check("s1_c8_done", 32'(done), 32'd0);

    // Scenario 2: address wrap
    run_stream(8'hFE, 4, 0);
    // Scenario 3: backpressure with long stalls
    run_stream(8'h40, 16, 1);

    // Scenario 4: zero length
    start = 1'b1; start_addr = 8'h33; length = 9'd0;
    #1;
    check("s4_mem_en_c0", 32'(mem_en), 32'd0);
    tick();
    start = 1'b0;
    check("s4_done", 32'(done), 32'd1);
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_mem_en", 32'(mem_en), 32'd0);
    tick();
    check("s4_done_clear", 32'(done), 32'd0);
    check("s4_mem_en2", 32'(mem_en), 32'd0);

    // Scenario 5: full address space
    run_stream(8'h00, 256, 0);

    // Scenario 6: abort after 3 pops, then reset mid-transfer
    begin
      int pops = 0;
      start = 1'b1; start_addr = 8'h20; length = 9'd10;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40 && pops < 3; c++) begin
        if (out_valid && out_ready) pops++;
        if (pops < 3) tick();
      end
      check("s6_pops", 32'(pops), 32'd3);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("s6_abort_valid", 32'(out_valid), 32'd0);
      check("s6_abort_busy", 32'(busy), 32'd0);
      check("s6_abort_done", 32'(done), 32'd0);
      for (int c = 0; c < 4; c++) begin
        tick();
        check("s6_post_abort_idle", 32'(out_valid | done | mem_en), 32'd0);
      end
    end
    start = 1'b1; start_addr = 8'h80; length = 9'd8;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("s6_run2_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    check("s6_rst_valid", 32'(out_valid), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    check("s6_rst_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    tick();
    check("s6_rel_done", 32'(done), 32'd0);
    run_stream(8'h10, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Bus-side reader for a single port of the team's dual-port block RAM (enable + address in, registered data out, 1-cycle read latency).
- On a start command, reads a contiguous address range and presents the words on a valid/ready stream.
- Absorbs the RAM pipeline through an internal 4-entry buffer, so downstream backpressure never loses in-flight read data.
- Used wherever a consumer (video fetch, DMA copier, serial TX) must drain a RAM region written by another agent on the other port.

Parameters:
DATAWIDTH, 8, width of RAM word and stream data
ADDRWIDTH, 8, RAM address width; address space 2**ADDRWIDTH words

Ports:
clock  input  1  single clock for all logic; RAM port on same clock
reset_n  input  1  synchronous, active-low reset
start  input  1  command strobe; sampled only in IDLE
start_addr  input  ADDRWIDTH  first address to read
length  input  ADDRWIDTH+1  word count, 0..2**ADDRWIDTH
abort  input  1  synchronous cancel of current transfer
busy  output  1  high from cycle after accepted start until done or abort
done  output  1  one-cycle pulse after final word handshake
mem_en  output  1  RAM port enable (read only; RAM write-enable tied low externally)
mem_addr  output  ADDRWIDTH  RAM port address
mem_q  input  DATAWIDTH  RAM read data, valid the cycle after the edge sampling mem_en
out_valid  output  1  stream data valid
out_data  output  DATAWIDTH  stream data
out_last  output  1  qualifies final word of the transfer
out_ready  input  1  downstream accept

Behaviour:
- Reset (reset_n=0 at an edge):
  - State → IDLE; busy, done, out_valid, out_last, mem_en = 0; mem_addr = 0.
  - Buffer and all counters cleared.
  - Applies mid-transfer with no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE → RUN when start=1 and length≠0:
  - Latch addr_ptr=start_addr, issue_left=length, pop_left=length.
  - busy=1 next cycle.
- IDLE with start=1 and length=0: no reads issued; done=1 for one cycle on next cycle; busy stays 0.
- start while busy: ignored.
- Issue (RUN):
  - mem_en = (state==RUN) && issue_left≠0 && occ<4. Combinational.
  - mem_addr = addr_ptr.
  - On each issue: addr_ptr+1 modulo 2**ADDRWIDTH (wraps 0xFF→0x00 at default); issue_left−1.
- Pipeline:
  - mem_q for an issue at edge E is written into the buffer at edge E+1.
  - occ = issued-but-not-popped count. +1 per issue, −1 per pop, both in the same cycle allowed. Never exceeds 4.
- RUN → DRAIN when the last word is issued (issue_left reaches 0).
- Output:
  - out_valid = buffer non-empty; out_data = buffer head.
  - Pop on out_valid && out_ready.
  - out_data/out_valid must remain stable while out_valid=1 and out_ready=0.
  - out_last = out_valid && pop_left==1.
- Latency: start sampled at edge 0 → mem_en cycle 1 → first out_valid in cycle 3. Steady throughput is 1 word/cycle with out_ready held high.
- Backpressure: issuing stalls at occ=4 and resumes the cycle after a pop.
- Completion: DRAIN → IDLE on the pop of the last word; done=1 the following cycle; busy=0 the same cycle done rises.
- Abort:
  - Abort=1 in RUN/DRAIN → IDLE at next edge.
  - Buffer flushed, in-flight read data discarded, out_valid=0 next cycle, no done.
  - Abort in IDLE: no effect.
  - Abort and start in the same IDLE cycle: start wins.
- Data ordering: words emitted strictly in address order; no duplication or loss under any out_ready pattern.

Test Plan:
1. RAM preloaded with mem[i]=i; start_addr=0x10, length=4, out_ready=1 → out_data 0x10,0x11,0x12,0x13 in cycles 3–6; out_last with 0x13; done pulse cycle 7.
2. start_addr=0xFE, length=4 → mem_addr sequence 0xFE,0xFF,0x00,0x01; out_data matches.
3. length=16, out_ready toggling with a pseudo-random pattern, including 10-cycle stalls → all 16 words in order; mem_en never issues with occ=4; out_data stable during each stall.
4. length=0 → no mem_en ever; done pulses once the cycle after start; busy stays 0.
5. length=256 from 0x00 with out_ready=1 → 256 words, throughput 1/cycle after fill; out_last only on word 0xFF.
6. Abort after 3 pops of a length-10 transfer, then reset_n=0 mid-transfer of a second run → out_valid 0 next cycle, no done, busy 0; a new start afterwards behaves as scenario 1.
